// File: rtl/keycode_drive_ctrl.sv
// Converts the keycode written by software into vehicle speed, steering and gear,
// with an IDLE/RUN/PAUSE game state. Vehicle controls advance once per frame_tick.
module keycode_drive_ctrl #(
    parameter logic [7:0] KEY_UP    = 8'h1A,
    parameter logic [7:0] KEY_DOWN  = 8'h16,
    parameter logic [7:0] KEY_LEFT  = 8'h04,
    parameter logic [7:0] KEY_RIGHT = 8'h07,
    parameter logic [7:0] KEY_GEAR  = 8'h2C,
    parameter logic [7:0] KEY_START = 8'h28,
    parameter int unsigned ACCEL     = 2,
    parameter int unsigned BRAKE     = 4,
    parameter int unsigned MAX_LOW   = 100,
    parameter int unsigned MAX_HIGH  = 200,
    parameter int unsigned STEER_MAX = 15,
    parameter int unsigned COAST_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic [7:0] speed,
    output logic [5:0] steer,
    output logic       gear,
    output logic       running,
    output logic       paused,
    output logic       key_press
);
    localparam int unsigned CW = (COAST_DIV > 1) ? $clog2(COAST_DIV) : 1;
    localparam logic [7:0] ACCEL8 = 8'(ACCEL);
    localparam logic [7:0] BRAKE8 = 8'(BRAKE);
    localparam logic [8:0] LIM_LO9 = 9'(MAX_LOW);
    localparam logic [8:0] LIM_HI9 = 9'(MAX_HIGH);
    localparam logic signed [5:0] STEER_HI = 6'(STEER_MAX);
    localparam logic signed [5:0] STEER_LO = -STEER_HI;
    localparam logic [CW-1:0] COAST_LAST = CW'(COAST_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         key_prev;
    logic [7:0]         speed_r, speed_nxt;
    logic signed [5:0]  steer_r, steer_nxt;
    logic               gear_r, gear_nxt;
    logic [CW-1:0]      coast_cnt, coast_nxt;
    logic               press, start_p, gear_p, frame_upd;
    logic [8:0]         lim9, sum9;
    logic [7:0]         lim8;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            key_prev  <= '0;
            key_press <= 1'b0;
            speed_r   <= '0;
            steer_r   <= '0;
            gear_r    <= 1'b0;
            coast_cnt <= '0;
        end else begin
            state     <= state_nxt;
            key_prev  <= keycode;
            key_press <= press;
            speed_r   <= speed_nxt;
            steer_r   <= steer_nxt;
            gear_r    <= gear_nxt;
            coast_cnt <= coast_nxt;
        end
    end

    always_comb begin
        press     = (keycode != 8'h00) && (keycode != key_prev);
        start_p   = press && (keycode == KEY_START);
        gear_p    = press && (keycode == KEY_GEAR);
        state_nxt = state;
        gear_nxt  = gear_r;
        speed_nxt = speed_r;
        steer_nxt = steer_r;
        coast_nxt = coast_cnt;
        lim9      = gear_r ? LIM_HI9 : LIM_LO9;
        lim8      = lim9[7:0];
        sum9      = {1'b0, speed_r} + {1'b0, ACCEL8};
        frame_upd = frame_tick && (state == RUN);

        case (state)
            IDLE:    if (start_p) state_nxt = RUN;
            RUN:     if (start_p) state_nxt = PAUSE;
            PAUSE:   if (start_p) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase

        if ((state == RUN) && gear_p)
            gear_nxt = ~gear_r;

        // Frame update reads the pre-press state and gear, so coincident presses apply next frame.
        if (frame_upd) begin
            if ((keycode == KEY_UP) || (keycode == KEY_DOWN))
                coast_nxt = '0;

            if ({1'b0, speed_r} > lim9) begin
                speed_nxt = ((speed_r - lim8) > BRAKE8) ? (speed_r - BRAKE8) : lim8;
            end else if (keycode == KEY_UP) begin
                speed_nxt = (sum9 > lim9) ? lim8 : sum9[7:0];
            end else if (keycode == KEY_DOWN) begin
                speed_nxt = (speed_r < BRAKE8) ? 8'h00 : (speed_r - BRAKE8);
            end else if (coast_cnt == COAST_LAST) begin
                coast_nxt = '0;
                if (speed_r != 8'h00)
                    speed_nxt = speed_r - 8'h01;
            end else begin
                coast_nxt = coast_cnt + CW'(1);
            end

            if (keycode == KEY_LEFT) begin
                if (steer_r > STEER_LO) steer_nxt = steer_r - 6'sd1;
            end else if (keycode == KEY_RIGHT) begin
                if (steer_r < STEER_HI) steer_nxt = steer_r + 6'sd1;
            end else if (steer_r > 6'sd0) begin
                steer_nxt = steer_r - 6'sd1;
            end else if (steer_r < 6'sd0) begin
                steer_nxt = steer_r + 6'sd1;
            end
        end
    end

    assign speed   = speed_r;
    assign steer   = steer_r;
    assign gear    = gear_r;
    assign running = (state == RUN);
    assign paused  = (state == PAUSE);

endmodule

// File: doc/keycode_drive_ctrl.md
Name: keycode_drive_ctrl

Overview:
- Consumes the 8-bit USB HID keycode written by the Nios II software into the keycode PIO output register (out_port).
- Converts it into game vehicle controls: speed, steering position and gear, plus a run/pause state machine.
- Sits between the keycode PIO and the track/sprite renderer.
- Control state advances once per video frame, on frame_tick.

Parameters:
- KEY_UP, 8'h1A, HID code that accelerates (W).
- KEY_DOWN, 8'h16, HID code that brakes (S).
- KEY_LEFT, 8'h04, HID code that steers left (A).
- KEY_RIGHT, 8'h07, HID code that steers right (D).
- KEY_GEAR, 8'h2C, HID code that toggles the gear (Space).
- KEY_START, 8'h28, HID code that starts and pauses the game (Enter).
- ACCEL, 2, speed increment per frame while accelerating.
- BRAKE, 4, speed decrement per frame while braking.
- MAX_LOW, 100, speed ceiling in low gear.
- MAX_HIGH, 200, speed ceiling in high gear.
- STEER_MAX, 15, magnitude limit for steer.
- COAST_DIV, 4, number of frames per 1-unit coast decrement.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous reset, active-low.
- keycode  in  8  keycode from the PIO register; synchronous to clk; 0 = no key.
- frame_tick  in  1  one-clk pulse per frame (vsync).
- speed  out  8  unsigned vehicle speed.
- steer  out  6  signed two's-complement steering position; negative = left.
- gear  out  1  0 = low, 1 = high.
- running  out  1  state == RUN.
- paused  out  1  state == PAUSE.
- key_press  out  1  one-clk pulse when a new nonzero keycode appears.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - speed = 0, steer = 0, gear = 0.
  - State = IDLE, so running = 0 and paused = 0.
  - key_press = 0, coast counter = 0, key_prev = 0.
  - Reset mid-operation aborts everything immediately.
- Edge detection:
  - key_prev is registered every clk.
  - press = (keycode != 0) && (keycode != key_prev).
  - key_press is registered, so it is asserted one clk after keycode changes.
  - A direct change from one nonzero code to another nonzero code is a new press.
- State machine (transitions on press, independent of frame_tick):
  - IDLE: press of KEY_START -> RUN.
  - RUN: press of KEY_START -> PAUSE.
  - PAUSE: press of KEY_START -> RUN.
  - All other keys cause no state transition.
- Gear:
  - In RUN only, a press of KEY_GEAR toggles gear.
  - Ignored in IDLE and PAUSE.
- Frame update: applies only when frame_tick = 1 and state == RUN. In IDLE and PAUSE, speed and steer hold and the coast counter holds.
- Speed (held key = current keycode value, level-sensitive), with limit = gear ? MAX_HIGH : MAX_LOW:
  - If speed > limit (downshift while fast): speed -= BRAKE, floored at limit. This takes priority over all keys.
  - Else if keycode == KEY_UP: speed = min(speed + ACCEL, limit). Compute with a 9-bit intermediate.
  - Else if keycode == KEY_DOWN: speed = max(speed - BRAKE, 0). Never wraps.
  - Else (coast): the coast counter increments each frame. When it reaches COAST_DIV-1 it wraps to 0 and speed decrements by 1, floored at 0.
  - The coast counter clears on any frame where KEY_UP or KEY_DOWN is held.
- Steer:
  - keycode == KEY_LEFT: steer -= 1, saturating at -STEER_MAX.
  - keycode == KEY_RIGHT: steer += 1, saturating at +STEER_MAX.
  - Otherwise: steer moves 1 toward 0 and holds at 0.
  - Because there is a single keycode, steering and throttle are mutually exclusive. While steering is held the speed path coasts.
- Simultaneous events:
  - When frame_tick coincides with a KEY_START press in RUN, the frame update still applies using the pre-transition state, and the state becomes PAUSE in the same clk.
  - When a KEY_GEAR press coincides with frame_tick, the speed limit uses the old gear for that frame.
- Outputs are registered. speed and steer change one clk after frame_tick.

Test Plan:
1. Reset, then keycode = 8'h1A held for 10 frames while in IDLE -> speed stays 0 and running = 0. Then press 8'h28 -> running = 1 one clk later, and key_press pulses for exactly 1 clk.
2. In RUN, low gear: hold 8'h1A for 60 frames -> speed reaches 100 after frame 50 and stays at 100. Press 8'h2C -> gear = 1. Hold 8'h1A 50 more frames -> speed = 200 and stays there.
3. With speed = 200 and gear = 1, press 8'h2C (gear = 0) with no key held -> speed follows 196, 192, ..., 104, 100 and then coasts 1 unit every 4 frames. Holding 8'h16 instead -> speed drops by 4 per frame and stops at 0 with no wrap.
4. Hold 8'h04 for 20 frames -> steer reaches -15 (6'h31) and holds. Release -> steer returns to 0 in 15 frames. Hold 8'h07 -> steer saturates at +15.
5. In RUN with speed = 50, press 8'h28 -> paused = 1 and speed/steer frozen over 10 frames with 8'h1A held. Press 8'h28 again -> RUN, and acceleration resumes on the next frame_tick.
6. Change keycode directly 8'h1A -> 8'h2C -> key_press pulses and gear toggles. Assert reset_n = 0 mid-frame -> all outputs are 0 and the state is IDLE immediately.
